// File: rtl/activation_arbiter.sv
// activation_arbiter
// Shares one four-phase activation unit (argument -> result -> error ->
// propagate) between N neuron requesters. A requester is granted the unit
// with round-robin priority and keeps it for the whole forward transaction,
// plus the backward transaction (error/propagate) when train was high at
// grant time. The granted requester's streams are muxed onto the unit and the
// unit's responses are demuxed back to it.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   train                   training mode, sampled when a grant is made
//   req_argument_*          per-requester argument streams (in from neurons)
//   req_result_*            per-requester result streams (data broadcast)
//   req_error_*             per-requester error streams (in from neurons)
//   req_propagate_*         per-requester propagate streams (data broadcast)
//   unit_train              registered train copy for the shared unit
//   unit_argument/result/error/propagate_*  the shared unit's four streams
//   grant                   one-hot current owner, zero when idle
//   busy                    a transaction is in progress
module activation_arbiter #(
  parameter int N     = 4,
  parameter int ARG_W = 16,
  parameter int RES_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               train,
  input  logic [N-1:0]       req_argument_valid,
  input  logic [N*ARG_W-1:0] req_argument_data,
  output logic [N-1:0]       req_argument_ready,
  output logic [N-1:0]       req_result_valid,
  output logic [RES_W-1:0]   req_result_data,
  input  logic [N-1:0]       req_result_ready,
  input  logic [N-1:0]       req_error_valid,
  input  logic [N*ARG_W-1:0] req_error_data,
  output logic [N-1:0]       req_error_ready,
  output logic [N-1:0]       req_propagate_valid,
  output logic [ARG_W-1:0]   req_propagate_data,
  input  logic [N-1:0]       req_propagate_ready,
  output logic               unit_train,
  output logic               unit_argument_valid,
  output logic [ARG_W-1:0]   unit_argument_data,
  input  logic               unit_argument_ready,
  input  logic               unit_result_valid,
  input  logic [RES_W-1:0]   unit_result_data,
  output logic               unit_result_ready,
  output logic               unit_error_valid,
  output logic [ARG_W-1:0]   unit_error_data,
  input  logic               unit_error_ready,
  input  logic               unit_propagate_valid,
  input  logic [ARG_W-1:0]   unit_propagate_data,
  output logic               unit_propagate_ready,
  output logic [N-1:0]       grant,
  output logic               busy
);

  localparam int PTR_W = $clog2(N);

  typedef enum logic [2:0] {IDLE, ARG, RES, ERR, PRP} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               train_q, train_d;

  logic [2*N-1:0]     validRot;
  logic [N-1:0]       selRot;
  logic [2*N-1:0]     selWide;
  logic [N-1:0]       selOneHot;

  logic               argValid, errValid, resReady, prpReady;
  logic [ARG_W-1:0]   argData, errData;
  logic [PTR_W-1:0]   nextPtr;

  // Round-robin pick: rotate the valids so bit 0 is the requester at ptr,
  // take the lowest set bit, then rotate the one-hot back. Doubling the
  // vectors makes the wrap work for any N, power of two or not.
  always_comb begin
    validRot = {req_argument_valid, req_argument_valid} >> ptr_q;
    selRot   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (validRot[j]) begin
        selRot    = '0;
        selRot[j] = 1'b1;
      end
    end
    selWide   = {{N{1'b0}}, selRot} << ptr_q;
    selOneHot = selWide[N-1:0] | selWide[2*N-1:N];
  end

  // Mux the granted requester's inputs; grant is one-hot or zero, so at most
  // one iteration matches. Also derive the pointer value used on release.
  always_comb begin
    argValid = 1'b0;
    errValid = 1'b0;
    resReady = 1'b0;
    prpReady = 1'b0;
    argData  = '0;
    errData  = '0;
    nextPtr  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        argValid = req_argument_valid[i];
        errValid = req_error_valid[i];
        resReady = req_result_ready[i];
        prpReady = req_propagate_ready[i];
        argData  = req_argument_data[i*ARG_W +: ARG_W];
        errData  = req_error_data[i*ARG_W +: ARG_W];
        nextPtr  = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign unit_argument_data = argData;
  assign unit_error_data    = errData;
  assign req_result_data    = unit_result_data;
  assign req_propagate_data = unit_propagate_data;
  assign unit_train         = train_q;
  assign grant              = grant_q;
  assign busy               = (state_q != IDLE);

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    ptr_d                = ptr_q;
    train_d              = train_q;
    unit_argument_valid  = 1'b0;
    unit_result_ready    = 1'b0;
    unit_error_valid     = 1'b0;
    unit_propagate_ready = 1'b0;
    req_argument_ready   = '0;
    req_result_valid     = '0;
    req_error_ready      = '0;
    req_propagate_valid  = '0;
    case (state_q)
      IDLE: begin
        if (|req_argument_valid) begin
          grant_d = selOneHot;
          train_d = train;
          state_d = ARG;
        end
      end
      ARG: begin
        unit_argument_valid = argValid;
        req_argument_ready  = grant_q & {N{unit_argument_ready}};
        if (argValid && unit_argument_ready) state_d = RES;
      end
      RES: begin
        unit_result_ready = resReady;
        req_result_valid  = grant_q & {N{unit_result_valid}};
        if (unit_result_valid && resReady) begin
          if (train_q) begin
            state_d = ERR;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = nextPtr;
          end
        end
      end
      ERR: begin
        unit_error_valid = errValid;
        req_error_ready  = grant_q & {N{unit_error_ready}};
        if (errValid && unit_error_ready) state_d = PRP;
      end
      PRP: begin
        unit_propagate_ready = prpReady;
        req_propagate_valid  = grant_q & {N{unit_propagate_valid}};
        if (unit_propagate_valid && prpReady) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nextPtr;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      train_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      train_q <= train_d;
    end
  end

endmodule

// File: tb/tb_activation_arbiter.sv
// tb_activation_arbiter
// Directed bench for activation_arbiter with N=4. The bench plays both the
// neuron requesters and the shared activation unit. Every argument a
// requester presents is pushed to a scoreboard as (requester, data); when the
// unit side sees an argument it pops the oldest entry and checks grant and
// data against it.
module tb_activation_arbiter;

  localparam int N     = 4;
  localparam int ARG_W = 16;
  localparam int RES_W = 8;

  typedef struct {
    int               idx;
    logic [ARG_W-1:0] arg;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               train;
  logic [N-1:0]       req_argument_valid;
  logic [N*ARG_W-1:0] req_argument_data;
  logic [N-1:0]       req_argument_ready;
  logic [N-1:0]       req_result_valid;
  logic [RES_W-1:0]   req_result_data;
  logic [N-1:0]       req_result_ready;
  logic [N-1:0]       req_error_valid;
  logic [N*ARG_W-1:0] req_error_data;
  logic [N-1:0]       req_error_ready;
  logic [N-1:0]       req_propagate_valid;
  logic [ARG_W-1:0]   req_propagate_data;
  logic [N-1:0]       req_propagate_ready;
  logic               unit_train;
  logic               unit_argument_valid;
  logic [ARG_W-1:0]   unit_argument_data;
  logic               unit_argument_ready;
  logic               unit_result_valid;
  logic [RES_W-1:0]   unit_result_data;
  logic               unit_result_ready;
  logic               unit_error_valid;
  logic [ARG_W-1:0]   unit_error_data;
  logic               unit_error_ready;
  logic               unit_propagate_valid;
  logic [ARG_W-1:0]   unit_propagate_data;
  logic               unit_propagate_ready;
  logic [N-1:0]       grant;
  logic               busy;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sbQ[$];
  exp_t e;

  activation_arbiter #(.N(N), .ARG_W(ARG_W), .RES_W(RES_W)) dut (
    .clock                (clock),
    .reset                (reset),
    .train                (train),
    .req_argument_valid   (req_argument_valid),
    .req_argument_data    (req_argument_data),
    .req_argument_ready   (req_argument_ready),
    .req_result_valid     (req_result_valid),
    .req_result_data      (req_result_data),
    .req_result_ready     (req_result_ready),
    .req_error_valid      (req_error_valid),
    .req_error_data       (req_error_data),
    .req_error_ready      (req_error_ready),
    .req_propagate_valid  (req_propagate_valid),
    .req_propagate_data   (req_propagate_data),
    .req_propagate_ready  (req_propagate_ready),
    .unit_train           (unit_train),
    .unit_argument_valid  (unit_argument_valid),
    .unit_argument_data   (unit_argument_data),
    .unit_argument_ready  (unit_argument_ready),
    .unit_result_valid    (unit_result_valid),
    .unit_result_data     (unit_result_data),
    .unit_result_ready    (unit_result_ready),
    .unit_error_valid     (unit_error_valid),
    .unit_error_data      (unit_error_data),
    .unit_error_ready     (unit_error_ready),
    .unit_propagate_valid (unit_propagate_valid),
    .unit_propagate_data  (unit_propagate_data),
    .unit_propagate_ready (unit_propagate_ready),
    .grant                (grant),
    .busy                 (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [N-1:0] oneHot(input int idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input int idx, input logic [ARG_W-1:0] arg);
    exp_t x;
    req_argument_valid[idx]                = 1'b1;
    req_argument_data[idx*ARG_W +: ARG_W]  = arg;
    x.idx = idx;
    x.arg = arg;
    sbQ.push_back(x);
  endtask

  task automatic checkIdle(input string tag);
    settle();
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_grant"}, grant, '0);
  endtask

  // Acts as the unit for the argument phase: waits (bounded) for a valid
  // argument, then checks it against the oldest scoreboard entry.
  task automatic serveArg(output exp_t ex, input int expLatency,
                          input logic expTrain, input bit dropValid);
    int waitCnt;
    waitCnt = 0;
    ex.idx  = 0;
    ex.arg  = '0;
    while (unit_argument_valid !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("argValidSeen", unit_argument_valid, 1'b1);
    if (unit_argument_valid !== 1'b1) return;
    if (sbQ.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard: argument seen with empty queue, data %0h", unit_argument_data);
      return;
    end
    ex = sbQ.pop_front();
    if (expLatency >= 0) checkOutput("grantLatency", waitCnt, expLatency);
    checkOutput("grant", grant, oneHot(ex.idx));
    checkOutput("unitArgData", unit_argument_data, ex.arg);
    checkOutput("unitTrain", unit_train, expTrain);
    checkOutput("busyArg", busy, 1'b1);
    unit_argument_ready = 1'b1;
    settle();
    checkOutput("argReady", req_argument_ready, oneHot(ex.idx));
    tick();
    unit_argument_ready = 1'b0;
    if (dropValid) req_argument_valid[ex.idx] = 1'b0;
  endtask

  task automatic serveRes(input exp_t ex, input logic [RES_W-1:0] resVal);
    unit_result_valid = 1'b1;
    unit_result_data  = resVal;
    settle();
    checkOutput("resValid", req_result_valid, oneHot(ex.idx));
    checkOutput("resData", req_result_data, resVal);
    checkOutput("unitResReady", unit_result_ready, 1'b1);
    tick();
    unit_result_valid = 1'b0;
  endtask

  task automatic serveErr(input exp_t ex, input logic [ARG_W-1:0] errVal);
    req_error_valid[ex.idx]                = 1'b1;
    req_error_data[ex.idx*ARG_W +: ARG_W]  = errVal;
    settle();
    checkOutput("unitErrValid", unit_error_valid, 1'b1);
    checkOutput("unitErrData", unit_error_data, errVal);
    checkOutput("errReadyHeld", req_error_ready, '0);
    unit_error_ready = 1'b1;
    settle();
    checkOutput("errReady", req_error_ready, oneHot(ex.idx));
    tick();
    unit_error_ready        = 1'b0;
    req_error_valid[ex.idx] = 1'b0;
  endtask

  task automatic servePrp(input exp_t ex, input logic [ARG_W-1:0] prpVal);
    unit_propagate_valid = 1'b1;
    unit_propagate_data  = prpVal;
    settle();
    checkOutput("prpValid", req_propagate_valid, oneHot(ex.idx));
    checkOutput("prpData", req_propagate_data, prpVal);
    checkOutput("unitPrpReady", unit_propagate_ready, 1'b1);
    tick();
    unit_propagate_valid = 1'b0;
  endtask

  initial begin
    int modelPtr;
    reset                = 1'b1;
    train                = 1'b0;
    req_argument_valid   = '0;
    req_argument_data    = '0;
    req_result_ready     = '1;
    req_error_valid      = '0;
    req_error_data       = '0;
    req_propagate_ready  = '1;
    unit_argument_ready  = 1'b0;
    unit_result_valid    = 1'b0;
    unit_result_data     = '0;
    unit_error_ready     = 1'b0;
    unit_propagate_valid = 1'b0;
    unit_propagate_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    settle();

    $display("[TB] reset state");
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstGrant", grant, '0);
    checkOutput("rstUnitTrain", unit_train, 1'b0);
    checkOutput("rstUnitArgValid", unit_argument_valid, 1'b0);
    checkOutput("rstArgReady", req_argument_ready, '0);
    checkOutput("rstResValid", req_result_valid, '0);

    $display("[TB] single forward, requester 2");
    applyStimulus(2, 16'h0005);
    serveArg(e, 1, 1'b0, 1'b1);
    serveRes(e, 8'hff);
    checkIdle("fwdRelease");

    // ptr is now 3; with everyone asking the order must rotate from there.
    $display("[TB] fairness, all requesters valid");
    modelPtr = 3;
    for (int i = 0; i < N; i++) begin
      req_argument_valid[i]             = 1'b1;
      req_argument_data[i*ARG_W +: ARG_W] = ARG_W'(16'h0100 + i);
    end
    for (int t = 0; t < 8; t++) begin
      exp_t x;
      x.idx = (modelPtr + t) % N;
      x.arg = ARG_W'(16'h0100 + x.idx);
      sbQ.push_back(x);
    end
    for (int t = 0; t < 8; t++) begin
      serveArg(e, 1, 1'b0, t >= 4);
      serveRes(e, 8'(8'h10 + t));
      checkIdle("fairRelease");
    end

    $display("[TB] training transaction, requester 1");
    train = 1'b1;
    applyStimulus(1, 16'h8000);
    serveArg(e, 1, 1'b1, 1'b1);
    train = 1'b0;
    serveRes(e, 8'h00);
    settle();
    checkOutput("trainStillBusy", busy, 1'b1);
    checkOutput("trainUnitTrain", unit_train, 1'b1);
    serveErr(e, 16'h1234);
    servePrp(e, 16'h1234);
    checkIdle("trainRelease");

    $display("[TB] next grant samples train=0");
    applyStimulus(2, 16'h0042);
    serveArg(e, 1, 1'b0, 1'b1);
    serveRes(e, 8'h11);
    checkIdle("noTrainSkipErr");

    $display("[TB] result backpressure, requester 0");
    applyStimulus(0, 16'h0777);
    serveArg(e, 1, 1'b0, 1'b1);
    req_result_ready[0] = 1'b0;
    unit_result_valid   = 1'b1;
    unit_result_data    = 8'h5a;
    applyStimulus(1, 16'h0111);
    for (int c = 0; c < 5; c++) begin
      settle();
      checkOutput("bpBusy", busy, 1'b1);
      checkOutput("bpGrant", grant, 4'b0001);
      checkOutput("bpUnitResReady", unit_result_ready, 1'b0);
      checkOutput("bpResValid", req_result_valid, 4'b0001);
      tick();
    end
    req_result_ready[0] = 1'b1;
    settle();
    checkOutput("bpRelease", unit_result_ready, 1'b1);
    tick();
    unit_result_valid = 1'b0;
    checkIdle("bpIdle");
    serveArg(e, 1, 1'b0, 1'b1);
    serveRes(e, 8'h33);
    checkIdle("bpSecond");

    // ptr is 2 here; requester 2 is granted and never released, so only
    // the reset can bring ptr back to 0.
    $display("[TB] reset during error phase");
    train = 1'b1;
    applyStimulus(2, 16'h0222);
    serveArg(e, 1, 1'b1, 1'b1);
    serveRes(e, 8'h22);
    req_error_valid[2]                 = 1'b1;
    req_error_data[2*ARG_W +: ARG_W]   = 16'h0abc;
    settle();
    checkOutput("errBeforeReset", unit_error_valid, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("rstErrBusy", busy, 1'b0);
    checkOutput("rstErrGrant", grant, '0);
    checkOutput("rstErrUnitTrain", unit_train, 1'b0);
    checkOutput("rstErrUnitErrValid", unit_error_valid, 1'b0);
    checkOutput("rstErrErrReady", req_error_ready, '0);
    checkOutput("rstErrPrpValid", req_propagate_valid, '0);
    reset              = 1'b0;
    train              = 1'b0;
    req_error_valid[2] = 1'b0;
    applyStimulus(0, 16'h0aa0);
    applyStimulus(2, 16'h0aa2);
    serveArg(e, 1, 1'b0, 1'b1);
    serveRes(e, 8'h44);
    checkIdle("postRstFirst");
    serveArg(e, 1, 1'b0, 1'b1);
    serveRes(e, 8'h55);
    checkIdle("postRstSecond");
    checkOutput("sbDrained", sbQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
